// File: rtl/display_pkg.sv
// Character encoding shared by the display manager and the 7-segment scanner.
// A code is {enable, glyph}; glyph_to_seg returns active-low segments a..g.
package display_pkg;

  typedef logic [5:0] char_t;
  typedef logic [4:0] glyph_t;

  localparam int unsigned CHAR_EN_BIT = 5;
  localparam char_t       CHAR_EN     = 6'h20;
  localparam logic [6:0]  SEG_OFF     = 7'h7F;

  localparam glyph_t CH_0     = 5'd0;
  localparam glyph_t CH_1     = 5'd1;
  localparam glyph_t CH_2     = 5'd2;
  localparam glyph_t CH_3     = 5'd3;
  localparam glyph_t CH_4     = 5'd4;
  localparam glyph_t CH_5     = 5'd5;
  localparam glyph_t CH_6     = 5'd6;
  localparam glyph_t CH_7     = 5'd7;
  localparam glyph_t CH_8     = 5'd8;
  localparam glyph_t CH_9     = 5'd9;
  localparam glyph_t CH_A     = 5'd10;
  localparam glyph_t CH_B     = 5'd11;
  localparam glyph_t CH_C     = 5'd12;
  localparam glyph_t CH_D     = 5'd13;
  localparam glyph_t CH_E     = 5'd14;
  localparam glyph_t CH_F     = 5'd15;
  localparam glyph_t CH_G     = 5'd16;
  localparam glyph_t CH_H     = 5'd17;
  localparam glyph_t CH_I     = 5'd18;
  localparam glyph_t CH_J     = 5'd19;
  localparam glyph_t CH_L     = 5'd20;
  localparam glyph_t CH_N     = 5'd21;
  localparam glyph_t CH_O     = 5'd22;
  localparam glyph_t CH_P     = 5'd23;
  localparam glyph_t CH_R     = 5'd24;
  localparam glyph_t CH_S     = 5'd25;
  localparam glyph_t CH_T     = 5'd26;
  localparam glyph_t CH_U     = 5'd27;
  localparam glyph_t CH_Y     = 5'd28;
  localparam glyph_t CH_DASH  = 5'd29;
  localparam glyph_t CH_UNDER = 5'd30;
  localparam glyph_t CH_BLANK = 5'd31;

  function automatic char_t mk_char(input glyph_t g);
    return {1'b1, g};
  endfunction

  // Table is written active-high (bit 0 = a .. bit 6 = g) and inverted on return.
  function automatic logic [6:0] glyph_to_seg(input glyph_t g);
    logic [6:0] on;
    case (g)
      CH_0:     on = 7'h3F;
      CH_1:     on = 7'h06;
      CH_2:     on = 7'h5B;
      CH_3:     on = 7'h4F;
      CH_4:     on = 7'h66;
      CH_5:     on = 7'h6D;
      CH_6:     on = 7'h7D;
      CH_7:     on = 7'h07;
      CH_8:     on = 7'h7F;
      CH_9:     on = 7'h6F;
      CH_A:     on = 7'h77;
      CH_B:     on = 7'h7C;
      CH_C:     on = 7'h39;
      CH_D:     on = 7'h5E;
      CH_E:     on = 7'h79;
      CH_F:     on = 7'h71;
      CH_G:     on = 7'h3D;
      CH_H:     on = 7'h76;
      CH_I:     on = 7'h30;
      CH_J:     on = 7'h1E;
      CH_L:     on = 7'h38;
      CH_N:     on = 7'h54;
      CH_O:     on = 7'h5C;
      CH_P:     on = 7'h73;
      CH_R:     on = 7'h50;
      CH_S:     on = 7'h6D;
      CH_T:     on = 7'h78;
      CH_U:     on = 7'h3E;
      CH_Y:     on = 7'h6E;
      CH_DASH:  on = 7'h40;
      CH_UNDER: on = 7'h08;
      CH_BLANK: on = 7'h00;
      default:  on = 7'h00;
    endcase
    return ~on;
  endfunction

endpackage

// File: rtl/display_scanner_char_decoder.sv
// Combinational character-code to active-low segment decoder.
// Codes with the enable bit clear are blank regardless of the glyph index.
module char_decoder
  import display_pkg::*;
(
  input  char_t      ch_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    if (ch_i[CHAR_EN_BIT]) begin
      seg_o = glyph_to_seg(ch_i[4:0]);
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scanner for an 8-digit common-anode 7-segment display.
// All eight codes are latched once per frame so text never tears mid-scan.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100_000,
  parameter int unsigned BLANK_CYCLES = 2_000,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  input  logic [7:0] blink,
  input  logic [7:0] dp,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp_n
);

  localparam int unsigned CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned PH_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BLINK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
  logic             phase_q, phase_d;

  char_t            buf_q [8];
  char_t            buf_d [8];
  logic [7:0]       blink_buf_q, blink_buf_d;
  logic [7:0]       dp_buf_q, dp_buf_d;

  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_n_q, dp_n_d;

  logic             frame_start;
  logic [2:0]       sel;
  logic [6:0]       slot_seg;
  logic             slot_lit;

  char_decoder u_char_decoder (
    .ch_i  (buf_q[idx_q]),
    .seg_o (slot_seg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      ph_cnt_q    <= '0;
      phase_q     <= 1'b0;
      blink_buf_q <= '0;
      dp_buf_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        buf_q[i] <= '0;
      end
      an_q        <= 8'hFF;
      seg_q       <= SEG_OFF;
      dp_n_q      <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ph_cnt_q    <= ph_cnt_d;
      phase_q     <= phase_d;
      blink_buf_q <= blink_buf_d;
      dp_buf_q    <= dp_buf_d;
      buf_q       <= buf_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
    end
  end

  assign frame_start = (idx_q == 3'd0) && (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    ph_cnt_d = ph_cnt_q + PH_W'(1);
    phase_d  = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
    if (ph_cnt_q == PH_LAST) begin
      ph_cnt_d = '0;
      phase_d  = ~phase_q;
    end
  end

  always_comb begin
    buf_d       = buf_q;
    blink_buf_d = blink_buf_q;
    dp_buf_d    = dp_buf_q;
    if (frame_start) begin
      buf_d[0]    = d1;
      buf_d[1]    = d2;
      buf_d[2]    = d3;
      buf_d[3]    = d4;
      buf_d[4]    = d5;
      buf_d[5]    = d6;
      buf_d[6]    = d7;
      buf_d[7]    = d8;
      blink_buf_d = blink;
      dp_buf_d    = dp;
    end
  end

  // A disabled code with its dp set still lights the anode so the point shows.
  assign sel      = 3'd7 - idx_q;
  assign slot_lit = (cnt_q >= CNT_BLANK)
                  && !(phase_q && blink_buf_q[sel])
                  && (buf_q[idx_q][CHAR_EN_BIT] || dp_buf_q[sel]);

  always_comb begin
    an_d   = 8'hFF;
    seg_d  = SEG_OFF;
    dp_n_d = 1'b1;
    if (slot_lit) begin
      an_d[sel] = 1'b0;
      seg_d     = slot_seg;
      dp_n_d    = ~dp_buf_q[sel];
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp_n = dp_n_q;

endmodule
